// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequencer for the CPU's signed MUL/DIV unit. One op is accepted per start
//   pulse while idle. A MUL uses the external combinational Booth multiplier,
//   which is fed from registered operands and given a fixed settle window. A DIV
//   runs an internal restoring divider, one quotient bit per clock. The result
//   appears on hi_out/lo_out together with a one-cycle done/hi_lo_we strobe.
//
//   Ports
//     clk          system clock, rising edge
//     clr_n        asynchronous active-low reset
//     start        op request, sampled only while busy is low
//     op           0 = MUL, 1 = DIV (both signed)
//     op_a, op_b   multiplicand/dividend, multiplier/divisor
//     mul_a, mul_b registered operands driving the Booth multiplier
//     mul_z        product returned by the Booth multiplier
//     busy         high while in MUL, DIV or FIX
//     done         one-cycle result-valid pulse
//     hi_lo_we     write strobe for the HI/LO registers (same as done)
//     hi_out       MUL: upper product half, DIV: remainder
//     lo_out       MUL: lower product half, DIV: quotient
//     div_by_zero  set with done for a DIV by zero, cleared on the next accept
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_MUL  | multiplier settling, product captured on the last count
//   S_DIV  | one restoring iteration per clock (or the divide-by-zero exit)
//   S_FIX  | sign correction of quotient and remainder
//   S_DONE | result strobe; a new op may be accepted in this cycle
module muldiv_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_z,
  output logic               busy,
  output logic               done,
  output logic               hi_lo_we,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               div_by_zero
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_sh, rem_diff;

  // Magnitudes as unsigned; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  assign abs_a = op_a[WIDTH-1] ? (-op_a) : op_a;
  assign abs_b = op_b[WIDTH-1] ? (-op_b) : op_b;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder and quotient bits enter at the LSB.
  assign rem_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign hi_lo_we    = done;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d   = op_a;
          b_d   = op_b;
          dbz_d = 1'b0;
          rem_d = '0;
          quo_d = abs_a;
          dvs_d = abs_b;
          if (op) begin
            state_d = S_DIV;
            cnt_d   = CW'(WIDTH - 1);
          end else begin
            state_d = S_MUL;
            cnt_d   = CW'(MUL_CYCLES - 1);
          end
        end
      end

      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_z;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DIV: begin
        if (b_q == '0) begin
          hi_d    = a_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          if (!rem_diff[WIDTH]) begin
            rem_d = rem_diff;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      S_FIX: begin
        // Truncating division: quotient sign from both operands, remainder
        // takes the dividend's sign. MIN / -1 wraps back to MIN.
        lo_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (-quo_q) : quo_q;
        hi_d    = a_q[WIDTH-1] ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule
